// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 keyboard decoder: scan codes, button bit
// indices, receive FSM state encoding and the opposite-direction cancel helper.
package kbd_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } rx_state_e;

  // Prefix bytes
  localparam logic [7:0] ScExt   = 8'hE0;
  localparam logic [7:0] ScBrk   = 8'hF0;

  // Player 1 (non-extended)
  localparam logic [7:0] ScW     = 8'h1D;
  localparam logic [7:0] ScS     = 8'h1B;
  localparam logic [7:0] ScA     = 8'h1C;
  localparam logic [7:0] ScD     = 8'h23;
  localparam logic [7:0] ScSpace = 8'h29;

  // Player 2 (arrows are extended, Enter is not)
  localparam logic [7:0] ScUp    = 8'h75;
  localparam logic [7:0] ScDown  = 8'h72;
  localparam logic [7:0] ScLeft  = 8'h6B;
  localparam logic [7:0] ScRight = 8'h74;
  localparam logic [7:0] ScEnter = 8'h5A;

  // Button bit indices
  localparam int unsigned BtnUp    = 0;
  localparam int unsigned BtnDown  = 1;
  localparam int unsigned BtnLeft  = 2;
  localparam int unsigned BtnRight = 3;
  localparam int unsigned BtnFire  = 4;

  // Drop both bits of an opposing pair while both are held
  function automatic logic [4:0] cancel_opposite(input logic [4:0] btns);
    logic [4:0] res;
    res = btns;
    if (btns[BtnUp] && btns[BtnDown]) begin
      res[BtnUp]   = 1'b0;
      res[BtnDown] = 1'b0;
    end
    if (btns[BtnLeft] && btns[BtnRight]) begin
      res[BtnLeft]  = 1'b0;
      res[BtnRight] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: 2-FF synchronizers, ps2_clk glitch filter, 11-bit
// receive FSM with odd-parity/stop check and an inactivity timeout.
// rx_byte/rx_valid/rx_err are combinational and valid in the cycle the stop-bit
// falling edge (or the timeout) is seen; the decoder registers them.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 25000
) (
  input  logic       clk_25m,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int unsigned FltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            flt_q;
  logic [FltW-1:0] flt_cnt_q;
  logic            flt_hit, fall;

  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;

  // FILTER_LEN-th consecutive sample differing from the filtered level flips it
  assign flt_hit = (clk_s2_q != flt_q) && (flt_cnt_q == FltW'(FILTER_LEN - 1));
  assign fall    = flt_hit && flt_q;
  assign rx_byte = shift_q;

  // Synchronizers and ps2_clk filter; idle bus level is 1
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      flt_q     <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      if (clk_s2_q == flt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_hit) begin
        flt_q     <= clk_s2_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  // Receive FSM state and datapath registers
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Next-state, frame check and timeout
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    rx_valid  = 1'b0;
    rx_err    = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!dat_s2_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          // Data plus parity must hold an odd number of ones
          if (dat_s2_q && (^{shift_q, par_q})) rx_valid = 1'b1;
          else                                 rx_err   = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
        state_d  = StIdle;
        to_cnt_d = '0;
        rx_err   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard to two-player button decoder. Tracks E0/F0 prefixes and keeps a
// held-key vector per player.
// Optional feature macro: KBD_OPPOSITE_CANCEL_EN (up+down or left+right held
// drives both output bits of that pair low; held state is kept).
module keyboard_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 25000
) (
  input  logic       clk_25m,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] player1_btns,
  output logic [4:0] player2_btns,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  logic       ext_q, ext_d, brk_q, brk_d;
  logic [4:0] held1_q, held1_d, held2_q, held2_d;
  logic [7:0] code_q;
  logic       valid_q, err_q;

  ps2_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ps2_rx (
    .clk_25m  (clk_25m),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  // Prefix flags and key map lookup on each accepted byte
  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    held1_d = held1_q;
    held2_d = held2_q;
    if (rx_valid) begin
      if (rx_byte == ScExt) begin
        ext_d = 1'b1;
      end else if (rx_byte == ScBrk) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        case ({ext_q, rx_byte})
          {1'b0, ScW}:     held1_d[BtnUp]    = !brk_q;
          {1'b0, ScS}:     held1_d[BtnDown]  = !brk_q;
          {1'b0, ScA}:     held1_d[BtnLeft]  = !brk_q;
          {1'b0, ScD}:     held1_d[BtnRight] = !brk_q;
          {1'b0, ScSpace}: held1_d[BtnFire]  = !brk_q;
          {1'b1, ScUp}:    held2_d[BtnUp]    = !brk_q;
          {1'b1, ScDown}:  held2_d[BtnDown]  = !brk_q;
          {1'b1, ScLeft}:  held2_d[BtnLeft]  = !brk_q;
          {1'b1, ScRight}: held2_d[BtnRight] = !brk_q;
          {1'b0, ScEnter}: held2_d[BtnFire]  = !brk_q;
          default: ;
        endcase
      end
    end
  end

  // Decode state and registered outputs; all update on the same edge
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      held1_q <= '0;
      held2_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      held1_q <= held1_d;
      held2_q <= held2_d;
      valid_q <= rx_valid;
      err_q   <= rx_err;
      if (rx_valid) code_q <= rx_byte;
    end
  end

  assign scan_code  = code_q;
  assign scan_valid = valid_q;
  assign frame_err  = err_q;

`ifdef KBD_OPPOSITE_CANCEL_EN
  assign player1_btns = cancel_opposite(held1_q);
  assign player2_btns = cancel_opposite(held2_q);
`else
  assign player1_btns = held1_q;
  assign player2_btns = held2_q;
`endif

endmodule

// File: tb/tb_keyboard_decoder.sv
// Self-checking bench for keyboard_decoder: a table of frames with hand-derived
// expectations, multi-cycle corner cases (latency, timeout, reset mid-frame,
// opposite cancel) and random frames checked against a key-map model.
module tb_keyboard_decoder;

  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int HALF = 12;

  logic       clk_25m = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [4:0] player1_btns, player2_btns;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;

  keyboard_decoder #(
    .FILTER_LEN  (FL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_25m      (clk_25m),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .player1_btns (player1_btns),
    .player2_btns (player2_btns),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .frame_err    (frame_err)
  );

  always #20 clk_25m = ~clk_25m;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_valid = 0, n_err = 0, n_overlap = 0;
  int valid_cyc = 0, err_cyc = 0;
  int last_fall_cyc = 0;

  always @(posedge clk_25m) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk_25m) begin
    if (scan_valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
    end
    if (frame_err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (scan_valid && frame_err) n_overlap <= n_overlap + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive the first nbits of an 11-bit frame; inputs change on negedge
  task automatic send_frame(input logic [7:0] code, input bit flip, input bit bstop,
                            input int nbits);
    logic [10:0] bits;
    bits = {~bstop, (~^code) ^ flip, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_25m);
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk_25m);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk_25m);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk_25m);
  endtask

  // Behavioural model: key map indexed by {ext, byte} -> player*8 + bit
  int         key_map[int];
  logic [4:0] m_held1, m_held2;
  logic [7:0] m_code;
  bit         m_ext, m_brk;
  int         m_nvalid = 0, m_nerr = 0;

  task automatic model_reset();
    m_held1 = '0;
    m_held2 = '0;
    m_code  = '0;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad);
    int idx;
    if (bad) begin
      m_nerr++;
      return;
    end
    m_nvalid++;
    m_code = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      idx = (m_ext ? 256 : 0) + int'(b);
      if (key_map.exists(idx)) begin
        if (key_map[idx] / 8 == 1) m_held1[key_map[idx] % 8] = !m_brk;
        else                       m_held2[key_map[idx] % 8] = !m_brk;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  function automatic logic [4:0] model_out(input logic [4:0] h);
    logic [4:0] o;
    o = h;
`ifdef KBD_OPPOSITE_CANCEL_EN
    if (h[0] && h[1]) o[1:0] = 2'b00;
    if (h[2] && h[3]) o[3:2] = 2'b00;
`endif
    return o;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_p1"},   int'(player1_btns), int'(model_out(m_held1)));
    check({tag, "_p2"},   int'(player2_btns), int'(model_out(m_held2)));
    check({tag, "_code"}, int'(scan_code),    int'(m_code));
  endtask

  typedef struct {
    logic [7:0] code;
    bit         flip;
    bit         bstop;
    logic [4:0] p1;
    logic [4:0] p2;
    logic [7:0] scode;
    int         dv;
    int         de;
  } vec_t;

  localparam int NV = 17;
  vec_t       vecs[NV];
  logic [7:0] pool[15];

  initial begin
    int v0, e0;
    logic [7:0] c;
    bit bad;

    key_map[int'(8'h1D)] = 8 + 0;  key_map[int'(8'h1B)] = 8 + 1;
    key_map[int'(8'h1C)] = 8 + 2;  key_map[int'(8'h23)] = 8 + 3;
    key_map[int'(8'h29)] = 8 + 4;
    key_map[256 + int'(8'h75)] = 16 + 0;  key_map[256 + int'(8'h72)] = 16 + 1;
    key_map[256 + int'(8'h6B)] = 16 + 2;  key_map[256 + int'(8'h74)] = 16 + 3;
    key_map[int'(8'h5A)] = 16 + 4;

    //            code   flp bst p1        p2        scode  dv de
    vecs[0]  = '{8'h1D, 0, 0, 5'b00001, 5'b00000, 8'h1D, 1, 0};
    vecs[1]  = '{8'hF0, 0, 0, 5'b00001, 5'b00000, 8'hF0, 1, 0};
    vecs[2]  = '{8'h1D, 0, 0, 5'b00000, 5'b00000, 8'h1D, 1, 0};
    vecs[3]  = '{8'hE0, 0, 0, 5'b00000, 5'b00000, 8'hE0, 1, 0};
    vecs[4]  = '{8'h6B, 0, 0, 5'b00000, 5'b00100, 8'h6B, 1, 0};
    vecs[5]  = '{8'h29, 0, 0, 5'b10000, 5'b00100, 8'h29, 1, 0};
    vecs[6]  = '{8'h1C, 1, 0, 5'b10000, 5'b00100, 8'h29, 0, 1};
    vecs[7]  = '{8'h1D, 0, 1, 5'b10000, 5'b00100, 8'h29, 0, 1};
    vecs[8]  = '{8'h5A, 0, 0, 5'b10000, 5'b10100, 8'h5A, 1, 0};
    vecs[9]  = '{8'hE0, 0, 0, 5'b10000, 5'b10100, 8'hE0, 1, 0};
    vecs[10] = '{8'hF0, 0, 0, 5'b10000, 5'b10100, 8'hF0, 1, 0};
    vecs[11] = '{8'h6B, 0, 0, 5'b10000, 5'b10000, 8'h6B, 1, 0};
    vecs[12] = '{8'h55, 0, 0, 5'b10000, 5'b10000, 8'h55, 1, 0};
    vecs[13] = '{8'hE0, 0, 0, 5'b10000, 5'b10000, 8'hE0, 1, 0};
    vecs[14] = '{8'h1D, 0, 0, 5'b10000, 5'b10000, 8'h1D, 1, 0};
    vecs[15] = '{8'h1D, 0, 0, 5'b10001, 5'b10000, 8'h1D, 1, 0};
    vecs[16] = '{8'h29, 0, 0, 5'b10001, 5'b10000, 8'h29, 1, 0};

    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B,
             8'h74, 8'h5A, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h55};

    // Reset state
    model_reset();
    repeat (4) @(negedge clk_25m);
    check("rst_p1",    int'(player1_btns), 0);
    check("rst_p2",    int'(player2_btns), 0);
    check("rst_code",  int'(scan_code),    0);
    check("rst_valid", int'(scan_valid),   0);
    check("rst_err",   int'(frame_err),    0);
    rst = 1'b0;
    repeat (4) @(negedge clk_25m);

    // Table-driven frames
    for (int i = 0; i < NV; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[i].code, vecs[i].flip, vecs[i].bstop, 11);
      model_frame(vecs[i].code, vecs[i].flip | vecs[i].bstop);
      check($sformatf("vec%0d_p1", i),    int'(player1_btns), int'(vecs[i].p1));
      check($sformatf("vec%0d_p2", i),    int'(player2_btns), int'(vecs[i].p2));
      check($sformatf("vec%0d_code", i),  int'(scan_code),    int'(vecs[i].scode));
      check($sformatf("vec%0d_valid", i), n_valid - v0,       vecs[i].dv);
      check($sformatf("vec%0d_err", i),   n_err - e0,         vecs[i].de);
      if (i == 2) check("three_valid_pulses", n_valid, 3);
    end

    // Timeout: start + 4 data bits, then the clock stalls
    e0 = n_err;
    v0 = n_valid;
    send_frame(8'h00, 0, 0, 5);
    for (int k = 0; k < TO + 100 && n_err == e0; k++) @(negedge clk_25m);
    m_nerr++;
    check("timeout_err",     n_err - e0,                1);
    check("timeout_valid",   n_valid - v0,              0);
    check("timeout_cycles",  err_cyc - last_fall_cyc,   FL + 2 + TO);
    check_model("timeout");

    // Valid frame after the timeout, with output latency
    send_frame(8'h23, 0, 0, 11);
    model_frame(8'h23, 1'b0);
    check("after_to_p1_bit3", int'(player1_btns[3]), 1);
    check("valid_latency",    valid_cyc - last_fall_cyc, FL + 2);
    check_model("after_to");

    // Reset in the middle of a frame
    send_frame(8'h1B, 0, 0, 6);
    @(negedge clk_25m);
    rst = 1'b1;
    @(negedge clk_25m);
    check("midrst_p1",    int'(player1_btns), 0);
    check("midrst_p2",    int'(player2_btns), 0);
    check("midrst_code",  int'(scan_code),    0);
    check("midrst_valid", int'(scan_valid),   0);
    check("midrst_err",   int'(frame_err),    0);
    rst = 1'b0;
    model_reset();
    repeat (TO + 20) @(negedge clk_25m);
    send_frame(8'h1B, 0, 0, 11);
    model_frame(8'h1B, 1'b0);
    check("postrst_p1", int'(player1_btns), 5'b00010);
    check_model("postrst");

    // W and S held together, then release S
    send_frame(8'h1D, 0, 0, 11);
    model_frame(8'h1D, 1'b0);
`ifdef KBD_OPPOSITE_CANCEL_EN
    check("ws_held_p1", int'(player1_btns), 5'b00000);
`else
    check("ws_held_p1", int'(player1_btns), 5'b00011);
`endif
    send_frame(8'hF0, 0, 0, 11);
    model_frame(8'hF0, 1'b0);
    send_frame(8'h1B, 0, 0, 11);
    model_frame(8'h1B, 1'b0);
    check("s_release_p1", int'(player1_btns), 5'b00001);

    // Random frames against the model
    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 19) < 15) ? pool[$urandom_range(0, 14)] : 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      send_frame(c, bad, 1'b0, 11);
      model_frame(c, bad);
      check_model($sformatf("rnd%0d", i));
    end

    repeat (4) @(negedge clk_25m);
    check("total_valid",   n_valid,   m_nvalid);
    check("total_err",     n_err,     m_nerr);
    check("valid_err_overlap", n_overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_decoder.md
KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal clk_25m samples needed before the filtered ps2_clk level changes.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 25000: idle clk_25m cycles (1 ms) before a partial frame is aborted.
REQ-003 SHALL have port clk_25m, input, 1: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1: PS/2 clock, asynchronous.
REQ-006 SHALL have port ps2_data, input, 1: PS/2 data, asynchronous.
REQ-007 SHALL have port player1_btns, output, 5: held-key vector, bit0 up, bit1 down, bit2 left, bit3 right, bit4 fire.
REQ-008 SHALL have port player2_btns, output, 5: held-key vector with the same bit order as player1_btns.
REQ-009 SHALL have port scan_code, output, 8: last correctly received byte.
REQ-010 SHALL have port scan_valid, output, 1: one-cycle pulse when scan_code updates.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers.
REQ-013 SHALL change the filtered ps2_clk level only after FILTER_LEN consecutive equal synchronized samples.
REQ-014 SHALL sample ps2_data on each falling edge of the filtered ps2_clk.
REQ-015 SHALL run a receive FSM with states IDLE, DATA, PARITY, STOP:
- IDLE->DATA on a sampled 0 (start bit); a sampled 1 keeps IDLE with no error.
- DATA collects 8 bits, LSB first, bit counter 0..7, then goes to PARITY.
- PARITY->STOP unconditionally, latching the parity bit.
- STOP->IDLE on the next falling edge.
REQ-016 SHALL accept a frame only if the 9 bits (data plus parity) contain an odd number of ones and the stop bit is 1; otherwise it pulses frame_err, discards the byte and leaves the decode flags unchanged.
REQ-017 SHALL, in any non-IDLE state, go to IDLE and pulse frame_err after TIMEOUT_CYC cycles with no falling edge; the timeout counter clears on every falling edge.
REQ-018 SHALL register scan_valid, scan_code and both button vectors on the clock edge after the cycle in which the stop-bit falling edge is detected (1-cycle latency); all of them update together.
REQ-019 SHALL keep decode flags ext and brk:
- Byte E0 sets ext; byte F0 sets brk.
- Any other byte is looked up using {ext, byte}; a mapped key sets its bit to !brk; then ext and brk both clear.
- An unmapped byte clears ext and brk and changes no button bit.
REQ-020 SHALL use this key map for player1: up 1D (W), down 1B (S), left 1C (A), right 23 (D), fire 29 (Space), all non-extended.
REQ-021 SHALL use this key map for player2: up E0 75, down E0 72, left E0 6B, right E0 74, fire 5A (Enter, non-extended).
REQ-022 SHALL treat a repeated make code as idempotent: the bit stays 1.
REQ-023 SHALL hold multiple keys simultaneously; a make of one key never clears another key's bit.
REQ-024 SHALL assert scan_valid for E0 and F0 bytes as well; scan_valid and frame_err are never high in the same cycle.

Reset
REQ-025 SHALL, on rst high at a clock edge, return the FSM to IDLE and clear the bit counter, timeout counter, ext and brk.
REQ-026 SHALL, on rst, drive scan_code 8'h00, scan_valid 0, frame_err 0, player1_btns 5'b0 and player2_btns 5'b0; rst mid-frame discards the partial frame.
REQ-027 SHALL let rst take priority over every simultaneous event; the synchronizers and the filter reset to level 1 (bus idle).

Configuration
REQ-028 SHALL, when KBD_OPPOSITE_CANCEL_EN is defined, drive both output bits 0 while both up and down are held, and likewise for left/right, per player; internal held state is unaffected, so releasing one key restores the other bit.
REQ-029 SHALL, without KBD_OPPOSITE_CANCEL_EN, output the raw held-key bits.

Structure
REQ-030 SHALL place the scan code constants, the button bit indices and the receive FSM state encoding in shared package kbd_pkg.
REQ-031 SHALL implement the synchronizers, filter, receive FSM and timeout in one sub-module, ps2_rx, which outputs byte, valid and err pulses; keyboard_decoder does the decode.

Verification
REQ-032 SHALL cover: a frame for 1D with correct parity -> scan_valid pulse, scan_code 1D, player1_btns 5'b00001.
REQ-033 SHALL cover: F0 then 1D -> player1_btns 5'b00000, and three scan_valid pulses in total across REQ-032/033.
REQ-034 SHALL cover: E0 6B, then 29 -> player2_btns 5'b00100 and player1_btns 5'b10000 at the same time.
REQ-035 SHALL cover: a frame for 1C with the parity bit flipped -> frame_err pulse, no scan_valid, buttons unchanged.
REQ-036 SHALL cover: start bit plus 4 data bits, then the clock stalls -> frame_err exactly TIMEOUT_CYC cycles after the last edge; a following valid 23 frame -> player1 bit3 = 1.
REQ-037 SHALL cover: W and S held with KBD_OPPOSITE_CANCEL_EN defined -> player1_btns 5'b00000; release S -> 5'b00001; rst mid-frame -> all outputs 0 on the next cycle.
